// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request handshake, result handshake and external-ALU bus of the
// ALU sequencer. The slave side is the sequencer; the master side is the upstream/ALU.
interface alu_sequencer_if #(
  parameter int L = 16,
  parameter int P = 0
);
  logic InValid, InReady, FlagsClear, OutValid, OutReady;
  logic [P:0] InOperation, AluOperation;
  logic [L-1:0] InA, InB, AluA, AluB, AluFlagsIn, AluR, AluFlagsOut;
  logic [L-1:0] OutR, OutFlags, Flags, OpCount;
  modport master (
    output InValid, InOperation, InA, InB, FlagsClear, OutReady, AluR, AluFlagsOut,
    input  InReady, AluOperation, AluA, AluB, AluFlagsIn, OutValid, OutR, OutFlags, Flags, OpCount
  );
  modport slave (
    input  InValid, InOperation, InA, InB, FlagsClear, OutReady, AluR, AluFlagsOut,
    output InReady, AluOperation, AluA, AluB, AluFlagsIn, OutValid, OutR, OutFlags, Flags, OpCount
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one request at a time, evaluates it on an external combinational
// ALU in a single cycle, and holds the result until the downstream drains it.
module alu_sequencer #(
  parameter int L = 16,
  parameter int P = 0
) (
  input logic Clock,
  input logic ResetN,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [P:0] opReg;
  logic [L-1:0] aReg, bReg, outR, outFlags, flags, opCount;
  logic outValid, inReady, accept;
  // Draining a result frees the slot in the same cycle, so DONE accepts back-to-back.
  assign inReady = (state == IDLE) || (state == DONE && bus.OutReady);
  assign accept = inReady && bus.InValid;
  assign bus.InReady = inReady;
  assign bus.AluOperation = opReg;
  assign bus.AluA = aReg;
  assign bus.AluB = bReg;
  assign bus.AluFlagsIn = flags;
  assign bus.OutValid = outValid;
  assign bus.OutR = outR;
  assign bus.OutFlags = outFlags;
  assign bus.Flags = flags;
  assign bus.OpCount = opCount;
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      state <= IDLE;
      opReg <= '0;
      aReg <= '0;
      bReg <= '0;
      outValid <= 1'b0;
      outR <= '0;
      outFlags <= '0;
      flags <= '0;
      opCount <= '0;
    end else begin
      if (accept) begin
        opReg <= bus.InOperation;
        aReg <= bus.InA;
        bReg <= bus.InB;
      end
      if (bus.FlagsClear) flags <= '0;
      case (state)
        IDLE: state <= accept ? EXEC : IDLE;
        EXEC: begin
          outR <= bus.AluR;
          outFlags <= bus.AluFlagsOut;
          // A coincident clear wins over the ALU's flag update.
          if (!bus.FlagsClear) flags <= bus.AluFlagsOut;
          opCount <= opCount + 1'b1;
          outValid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.OutReady) begin
          outValid <= 1'b0;
          state <= accept ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
